// File: rtl/ex_pkg.sv
// Shared EX-stage types and source-decode helpers used by the operand fetch
// and the scalar/vector source-decode logic.
package ex_pkg;

  localparam int unsigned SGPR_DEPTH     = 106;
  localparam int          OPFETCH_SLOTS  = 6;
  localparam int          OPFETCH_SLOT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } opfetch_state_e;

  typedef enum logic [1:0] {
    SRC_SGPR  = 2'd0,
    SRC_VGPR  = 2'd1,
    SRC_CONST = 2'd2
  } src_class_e;

  typedef struct packed {
    logic                      valid;
    logic [OPFETCH_SLOT_W-1:0] slot;
  } opfetch_tag_t;

  // bit8 selects the VGPR file; low codes beyond the SGPR file are literals/inline constants
  function automatic src_class_e scalar_src_decode(input logic [8:0] src,
                                                   input int unsigned limit);
    if (src[8])
      return SRC_VGPR;
    else if (32'(src[7:0]) < limit)
      return SRC_SGPR;
    else
      return SRC_CONST;
  endfunction

  function automatic logic slot_needs_read(input logic [8:0] src,
                                           input logic [1:0] src_idx,
                                           input logic [1:0] num_src,
                                           input int unsigned limit);
    return (src_idx < num_src) && (scalar_src_decode(src, limit) == SRC_SGPR);
  endfunction

  function automatic logic sgpr_pair_legal(input logic [7:0] base,
                                           input int unsigned limit);
    return !base[0] && ((32'(base) + 32'd1) < limit);
  endfunction

endpackage

// File: rtl/ex_opfetch_tag_pipe.sv
// Fixed-latency delay line that tracks which operand slot each granted SGPR
// read belongs to, so returning data can be steered without a handshake.
module ex_opfetch_tag_pipe
  import ex_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  opfetch_tag_t tag_in,
  output opfetch_tag_t tag_out,
  output logic         inflight
);

  opfetch_tag_t stage_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_out = stage_q[DEPTH-1];

  // Reads still travelling behind the output stage; the output stage itself
  // is consumed in the cycle it is presented.
  always_comb begin
    inflight = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      inflight = inflight | stage_q[i].valid;
    end
  end

endmodule

// File: rtl/ex_sgpr_operand_fetch.sv
// Gathers up to three raw SGPR source operands for one instruction through the
// single shared SGPR read port and presents them together on a valid/ready output.
//
// state | meaning
// IDLE  | accepting a request; sources captured and pending mask built on handshake
// ISSUE | requesting the lowest pending slot, one grant per cycle
// DRAIN | all reads granted, waiting for the last returns
// DONE  | operands valid, held until the consumer accepts
module ex_sgpr_operand_fetch
  import ex_pkg::*;
#(
  parameter int          RD_LAT     = 1,
  parameter int unsigned SGPR_LIMIT = SGPR_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [8:0]   in_src0,
  input  logic [8:0]   in_src1,
  input  logic [8:0]   in_src2,
  input  logic [1:0]   in_num_src,
  input  logic [2:0]   in_is64,
  output logic         sgpr_rd_req,
  output logic [7:0]   sgpr_rd_addr,
  input  logic         sgpr_rd_gnt,
  input  logic [31:0]  sgpr_rd_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [191:0] out_data,
  output logic         out_err
);

  opfetch_state_e                     state_q, state_d;
  logic [OPFETCH_SLOTS-1:0]           pending_q, pending_d;
  logic [2:0][7:0]                    base_q;
  logic [OPFETCH_SLOTS-1:0][31:0]     data_q;
  logic                               err_q;

  logic [2:0][8:0]                    src_in;
  logic [OPFETCH_SLOTS-1:0]           need_mask;
  logic                               need_err;
  logic [OPFETCH_SLOT_W-1:0]          cur_slot;
  logic                               capture;
  opfetch_tag_t                       push_tag;
  opfetch_tag_t                       ret_tag;
  logic                               inflight;

  assign src_in  = {in_src2, in_src1, in_src0};
  assign capture = (state_q == IDLE) && in_valid;

  // Illegal pairs still read their low half; only the hi slot is dropped.
  always_comb begin
    need_mask = '0;
    need_err  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (slot_needs_read(src_in[i], 2'(i), in_num_src, SGPR_LIMIT)) begin
        need_mask[2*i] = 1'b1;
        if (in_is64[i]) begin
          if (sgpr_pair_legal(src_in[i][7:0], SGPR_LIMIT))
            need_mask[2*i+1] = 1'b1;
          else
            need_err = 1'b1;
        end
      end
    end
  end

  always_comb begin
    cur_slot = '0;
    for (int k = OPFETCH_SLOTS - 1; k >= 0; k--) begin
      if (pending_q[k]) cur_slot = OPFETCH_SLOT_W'(k);
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    push_tag     = '0;
    sgpr_rd_req  = 1'b0;
    sgpr_rd_addr = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          pending_d = need_mask;
          state_d   = (|need_mask) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        sgpr_rd_req  = 1'b1;
        sgpr_rd_addr = base_q[cur_slot[2:1]] + {7'd0, cur_slot[0]};
        if (sgpr_rd_gnt) begin
          pending_d[cur_slot] = 1'b0;
          push_tag.valid      = 1'b1;
          push_tag.slot       = cur_slot;
          if (pending_d == '0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The output stage is written on this edge, so DONE may follow it directly.
        if (!inflight) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      base_q    <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (capture) begin
        base_q <= {in_src2[7:0], in_src1[7:0], in_src0[7:0]};
        data_q <= '0;
        err_q  <= need_err;
      end else if (ret_tag.valid) begin
        data_q[ret_tag.slot] <= sgpr_rd_data;
      end
    end
  end

  ex_opfetch_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .tag_in   (push_tag),
    .tag_out  (ret_tag),
    .inflight (inflight)
  );

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_ex_sgpr_operand_fetch.sv
// Directed bench for ex_sgpr_operand_fetch: one instance at RD_LAT=1 with an odd
// SGPR limit for pair-boundary cases, one at RD_LAT=2 for mid-flight reset.
module tb_ex_sgpr_operand_fetch;

  logic clk = 1'b0;
  logic rst, rst2;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic         in_valid1, in_ready1, gnt1, req1, out_valid1, out_ready1, err1;
  logic [8:0]   s0_1, s1_1, s2_1;
  logic [1:0]   num1;
  logic [2:0]   is64_1;
  logic [7:0]   addr1;
  logic [31:0]  rdata1;
  logic [191:0] data1;

  logic         in_valid2, in_ready2, gnt2, req2, out_valid2, out_ready2, err2;
  logic [8:0]   s0_2, s1_2, s2_2;
  logic [1:0]   num2;
  logic [2:0]   is64_2;
  logic [7:0]   addr2;
  logic [31:0]  rdata2;
  logic [191:0] data2;

  ex_sgpr_operand_fetch #(.RD_LAT(1), .SGPR_LIMIT(105)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_src0(s0_1), .in_src1(s1_1), .in_src2(s2_1), .in_num_src(num1), .in_is64(is64_1),
    .sgpr_rd_req(req1), .sgpr_rd_addr(addr1), .sgpr_rd_gnt(gnt1), .sgpr_rd_data(rdata1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(data1), .out_err(err1)
  );

  ex_sgpr_operand_fetch #(.RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_src0(s0_2), .in_src1(s1_2), .in_src2(s2_2), .in_num_src(num2), .in_is64(is64_2),
    .sgpr_rd_req(req2), .sgpr_rd_addr(addr2), .sgpr_rd_gnt(gnt2), .sgpr_rd_data(rdata2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(data2), .out_err(err2)
  );

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {8'h5A, a, ~a, a ^ 8'h3C};
  endfunction

  // SGPR read port models: data appears RD_LAT cycles after the granted cycle
  logic [7:0] addr_log1 [$];
  always @(posedge clk) begin : resp1
    logic       g;
    logic [7:0] a;
    g = req1 && gnt1;
    a = addr1;
    if (g) addr_log1.push_back(a);
    #1;
    rdata1 = g ? mem_word(a) : 32'hDEADBEEF;
  end

  logic       g2_d = 1'b0;
  logic [7:0] a2_d = '0;
  always @(posedge clk) begin : resp2
    logic       g;
    logic [7:0] a;
    g = req2 && gnt2;
    a = addr2;
    #1;
    rdata2 = g2_d ? mem_word(a2_d) : 32'hDEADBEEF;
    g2_d   = g;
    a2_d   = a;
  end

  logic       req_hist  [64];
  logic [7:0] addr_hist [64];

  task automatic do_req1(input logic [8:0] s0, input logic [8:0] s1, input logic [8:0] s2,
                         input logic [1:0] n, input logic [2:0] w, input int stall,
                         output int lat);
    @(posedge clk); #1;
    addr_log1.delete();
    s0_1 = s0; s1_1 = s1; s2_1 = s2; num1 = n; is64_1 = w;
    in_valid1 = 1'b1;
    out_ready1 = 1'b0;
    gnt1 = (stall == 0);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    lat = -1;
    for (int k = 1; k < 64 && lat < 0; k++) begin
      if (k == stall + 1) gnt1 = 1'b1;
      req_hist[k]  = req1;
      addr_hist[k] = addr1;
      if (out_valid1) lat = k;
      else begin
        @(posedge clk); #1;
      end
    end
    gnt1 = 1'b1;
  endtask

  task automatic accept1();
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready1 !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready1); else passed++;
    checks++; if ({req1, addr1} !== 9'd0) $display("FAIL reset_req_addr: got %b/%h want 0/00", req1, addr1); else passed++;
    checks++; if ({out_valid1, err1} !== 2'b00) $display("FAIL reset_valid_err: got %b%b want 00", out_valid1, err1); else passed++;
    checks++; if (data1 !== 192'd0) $display("FAIL reset_data: got %h want 0", data1); else passed++;
    rst = 1'b0; rst2 = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready1 !== 1'b1) $display("FAIL idle_in_ready: got %b want 1", in_ready1); else passed++;
    checks++; if (in_ready2 !== 1'b1) $display("FAIL idle_in_ready2: got %b want 1", in_ready2); else passed++;
  endtask

  task automatic test_two_32bit();
    int lat;
    logic [191:0] exp;
    do_req1(9'd5, 9'd9, 9'd0, 2'd2, 3'b000, 0, lat);
    exp = '0; exp[31:0] = mem_word(8'd5); exp[95:64] = mem_word(8'd9);
    checks++; if (lat != 4) $display("FAIL two32_latency: got %0d want 4", lat); else passed++;
    checks++; if (addr_log1.size() != 2) $display("FAIL two32_nreads: got %0d want 2", addr_log1.size()); else passed++;
    checks++; if ({req_hist[1], addr_hist[1], req_hist[2], addr_hist[2]} !== {1'b1, 8'd5, 1'b1, 8'd9})
      $display("FAIL two32_addr_seq: got %h,%h want 05,09", addr_hist[1], addr_hist[2]); else passed++;
    checks++; if (data1 !== exp) $display("FAIL two32_data: got %h want %h", data1, exp); else passed++;
    checks++; if (err1 !== 1'b0) $display("FAIL two32_err: got %b want 0", err1); else passed++;
    accept1();
  endtask

  task automatic test_64bit_mixed();
    int lat;
    logic [191:0] exp;
    do_req1(9'd10, 9'h105, 9'd255, 2'd3, 3'b001, 0, lat);
    exp = '0; exp[31:0] = mem_word(8'd10); exp[63:32] = mem_word(8'd11);
    checks++; if (lat != 4) $display("FAIL mixed_latency: got %0d want 4", lat); else passed++;
    checks++; if (addr_log1.size() != 2 || addr_log1[0] !== 8'd10 || addr_log1[1] !== 8'd11)
      $display("FAIL mixed_reads: got n=%0d want 10,11", addr_log1.size()); else passed++;
    checks++; if (data1 !== exp) $display("FAIL mixed_data: got %h want %h", data1, exp); else passed++;
    checks++; if (err1 !== 1'b0) $display("FAIL mixed_err: got %b want 0", err1); else passed++;
    accept1();
  endtask

  task automatic test_pair_err();
    int lat;
    logic [191:0] exp;
    do_req1(9'd7, 9'd0, 9'd0, 2'd1, 3'b001, 0, lat);
    exp = '0; exp[31:0] = mem_word(8'd7);
    checks++; if (err1 !== 1'b1) $display("FAIL odd_pair_err: got %b want 1", err1); else passed++;
    checks++; if (addr_log1.size() != 1 || addr_log1[0] !== 8'd7)
      $display("FAIL odd_pair_reads: got n=%0d want 1 (07)", addr_log1.size()); else passed++;
    checks++; if (lat != 3) $display("FAIL odd_pair_latency: got %0d want 3", lat); else passed++;
    checks++; if (data1 !== exp) $display("FAIL odd_pair_data: got %h want %h", data1, exp); else passed++;
    accept1();
    do_req1(9'd104, 9'd3, 9'd0, 2'd2, 3'b001, 0, lat);
    exp = '0; exp[31:0] = mem_word(8'd104); exp[95:64] = mem_word(8'd3);
    checks++; if (err1 !== 1'b1) $display("FAIL top_pair_err: got %b want 1", err1); else passed++;
    checks++; if (addr_log1.size() != 2 || addr_log1[0] !== 8'd104 || addr_log1[1] !== 8'd3)
      $display("FAIL top_pair_reads: got n=%0d want 104,3", addr_log1.size()); else passed++;
    checks++; if (lat != 4) $display("FAIL top_pair_latency: got %0d want 4", lat); else passed++;
    checks++; if (data1 !== exp) $display("FAIL top_pair_data: got %h want %h", data1, exp); else passed++;
    accept1();
  endtask

  task automatic test_no_reads();
    int lat;
    do_req1(9'd5, 9'd0, 9'd0, 2'd0, 3'b000, 0, lat);
    checks++; if (lat != 1) $display("FAIL nsrc0_latency: got %0d want 1", lat); else passed++;
    checks++; if (addr_log1.size() != 0 || req_hist[1] !== 1'b0)
      $display("FAIL nsrc0_reads: got n=%0d req=%b want 0", addr_log1.size(), req_hist[1]); else passed++;
    checks++; if ({data1, err1} !== 193'd0) $display("FAIL nsrc0_data: got %h err %b want 0", data1, err1); else passed++;
    accept1();
    do_req1(9'h100, 9'd200, 9'h1FF, 2'd3, 3'b111, 0, lat);
    checks++; if (lat != 1) $display("FAIL nosgpr_latency: got %0d want 1", lat); else passed++;
    checks++; if (addr_log1.size() != 0) $display("FAIL nosgpr_reads: got %0d want 0", addr_log1.size()); else passed++;
    checks++; if ({data1, err1} !== 193'd0) $display("FAIL nosgpr_data: got %h err %b want 0", data1, err1); else passed++;
    accept1();
  endtask

  task automatic test_gnt_stall();
    int lat;
    logic [191:0] exp;
    do_req1(9'd5, 9'd9, 9'd0, 2'd2, 3'b000, 3, lat);
    exp = '0; exp[31:0] = mem_word(8'd5); exp[95:64] = mem_word(8'd9);
    checks++; if (lat != 7) $display("FAIL stall_latency: got %0d want 7", lat); else passed++;
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if ({req_hist[k], addr_hist[k]} !== {1'b1, 8'd5})
        $display("FAIL stall_hold_c%0d: got req=%b addr=%h want 1/05", k, req_hist[k], addr_hist[k]);
      else passed++;
    end
    checks++; if (addr_log1.size() != 2 || addr_log1[0] !== 8'd5 || addr_log1[1] !== 8'd9)
      $display("FAIL stall_reads: got n=%0d want 5,9", addr_log1.size()); else passed++;
    checks++; if (data1 !== exp) $display("FAIL stall_data: got %h want %h", data1, exp); else passed++;
    accept1();
  endtask

  task automatic test_out_ready_stall();
    int lat;
    logic [191:0] exp;
    do_req1(9'd12, 9'd34, 9'd0, 2'd2, 3'b011, 0, lat);
    exp = '0;
    exp[31:0]   = mem_word(8'd12); exp[63:32]  = mem_word(8'd13);
    exp[95:64]  = mem_word(8'd34); exp[127:96] = mem_word(8'd35);
    checks++; if (lat != 6) $display("FAIL hold_latency: got %0d want 6", lat); else passed++;
    s0_1 = 9'd3; s1_1 = 9'd0; num1 = 2'd1; is64_1 = 3'b000; in_valid1 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid1 !== 1'b1 || data1 !== exp || in_ready1 !== 1'b0)
        $display("FAIL hold_c%0d: got v=%b rdy=%b data=%h want v=1 rdy=0 data=%h", c, out_valid1, in_ready1, data1, exp);
      else passed++;
    end
    in_valid1 = 1'b0;
    accept1();
    checks++; if ({out_valid1, in_ready1} !== 2'b01)
      $display("FAIL hold_release: got v=%b rdy=%b want 0/1", out_valid1, in_ready1); else passed++;
  endtask

  task automatic test_duplicates();
    int lat;
    logic [191:0] exp;
    do_req1(9'd20, 9'd20, 9'd40, 2'd3, 3'b100, 0, lat);
    exp = '0;
    exp[31:0]    = mem_word(8'd20); exp[95:64]   = mem_word(8'd20);
    exp[159:128] = mem_word(8'd40); exp[191:160] = mem_word(8'd41);
    checks++; if (lat != 6) $display("FAIL dup_latency: got %0d want 6", lat); else passed++;
    checks++; if (addr_log1.size() != 4 || addr_log1[0] !== 8'd20 || addr_log1[1] !== 8'd20 ||
                  addr_log1[2] !== 8'd40 || addr_log1[3] !== 8'd41)
      $display("FAIL dup_reads: got n=%0d want 20,20,40,41", addr_log1.size()); else passed++;
    checks++; if (data1 !== exp) $display("FAIL dup_data: got %h want %h", data1, exp); else passed++;
    accept1();
  endtask

  task automatic test_reset_midop();
    int lat;
    logic [191:0] exp;
    // completed request held in DONE, then reset clears it asynchronously
    @(posedge clk); #1;
    s0_2 = 9'd30; s1_2 = 9'd0; s2_2 = 9'd0; num2 = 2'd1; is64_2 = 3'b000; in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    for (int k = 0; k < 20 && !out_valid2; k++) begin
      @(posedge clk); #1;
    end
    exp = '0; exp[31:0] = mem_word(8'd30);
    checks++; if (out_valid2 !== 1'b1 || data2 !== exp)
      $display("FAIL lat2_done: got v=%b data=%h want 1/%h", out_valid2, data2, exp); else passed++;
    rst2 = 1'b1; #1;
    checks++; if ({out_valid2, err2, in_ready2} !== 3'b000 || data2 !== 192'd0)
      $display("FAIL rst_in_done: got v=%b data=%h want 0/0", out_valid2, data2); else passed++;
    @(posedge clk); #1;
    rst2 = 1'b0;
    // abort with one read in flight
    @(posedge clk); #1;
    s0_2 = 9'd60; num2 = 2'd1; in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    @(posedge clk); #1;
    rst2 = 1'b1; #1;
    checks++; if ({out_valid2, req2, addr2, in_ready2, err2} !== 12'd0 || data2 !== 192'd0)
      $display("FAIL rst_midop: got v=%b req=%b addr=%h rdy=%b data=%h want all 0", out_valid2, req2, addr2, in_ready2, data2);
    else passed++;
    @(posedge clk); #1;
    rst2 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if ({out_valid2, in_ready2} !== 2'b01 || data2 !== 192'd0)
      $display("FAIL rst_stale_return: got v=%b rdy=%b data=%h want 0/1/0", out_valid2, in_ready2, data2); else passed++;
    s0_2 = 9'h100; s1_2 = 9'd50; num2 = 2'd2; in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    lat = -1;
    for (int k = 1; k < 30 && lat < 0; k++) begin
      if (out_valid2) lat = k;
      else begin
        @(posedge clk); #1;
      end
    end
    exp = '0; exp[95:64] = mem_word(8'd50);
    checks++; if (lat != 4) $display("FAIL post_rst_latency: got %0d want 4", lat); else passed++;
    checks++; if (data2 !== exp) $display("FAIL post_rst_data: got %h want %h", data2, exp); else passed++;
    out_ready2 = 1'b1;
    @(posedge clk); #1;
    out_ready2 = 1'b0;
  endtask

  initial begin
    in_valid1 = 1'b0; out_ready1 = 1'b0; gnt1 = 1'b1; rdata1 = 32'hDEADBEEF;
    s0_1 = '0; s1_1 = '0; s2_1 = '0; num1 = '0; is64_1 = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; gnt2 = 1'b1; rdata2 = 32'hDEADBEEF;
    s0_2 = '0; s1_2 = '0; s2_2 = '0; num2 = '0; is64_2 = '0;
    test_reset();
    test_two_32bit();
    test_64bit_mixed();
    test_pair_err();
    test_no_reads();
    test_gnt_stall();
    test_out_ready_stall();
    test_duplicates();
    test_reset_midop();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
